// File: rtl/z80_mem_pkg.sv
// Shared types for the Z80 memory arbiter: owner tag, CPU access FSM state
// and the observation struct exported for checkers.
package z80_mem_pkg;

    localparam int VID_BURST_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } cpu_state_e;

    typedef struct packed {
        cpu_state_e state;
        owner_e     owner;
        logic [3:0] burst;
    } arb_dbg_t;

endpackage

// File: rtl/mem_arb.sv
// Single-port memory arbiter between a Z80-style CPU and a video fetcher.
// One grant per cycle; the read data returns one cycle later via the owner tag.
module mem_arb
    import z80_mem_pkg::*;
#(
    parameter int VID_BURST = VID_BURST_DEF
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        CPU_REQ,
    input  logic [15:0] CPU_A,
    input  logic [7:0]  CPU_DO,
    input  logic        CPU_W,
    output logic        CPU_HOLD,
    output logic [7:0]  CPU_DI,
    input  logic        VID_REQ,
    input  logic [15:0] VID_A,
    output logic        VID_ACK,
    output logic        VID_VALID,
    output logic [7:0]  VID_DI,
    output logic [15:0] MEM_A,
    output logic [7:0]  MEM_DO,
    output logic        MEM_W,
    input  logic [7:0]  MEM_DI,
    output arb_dbg_t    DBG
);

    // Handshakes: a video read transfers in any cycle with VID_REQ=1 and
    // VID_ACK=1, and its data appears with VID_VALID=1 exactly one cycle later.
    // The CPU holds CPU_REQ/address/data until it sees CPU_HOLD=1; a CPU grant
    // is followed by one DATA cycle in which CPU_HOLD=1 and CPU_DI is valid.

    localparam logic [3:0] BURST_MAX = 4'(VID_BURST);

    cpu_state_e state_q, state_d;
    owner_e     owner_q, owner_d;
    logic [3:0] burst_q, burst_d;
    logic       cpu_elig;
    logic       grant_cpu;
    logic       grant_vid;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

    // Grants are gated by RESET_N so nothing reaches memory while in reset.
    always_comb begin
        cpu_elig  = RESET_N && CPU_REQ && (state_q == ST_IDLE);
        grant_cpu = cpu_elig && (!VID_REQ || (burst_q == BURST_MAX));
        grant_vid = RESET_N && VID_REQ && !grant_cpu;

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_cpu) state_d = ST_DATA;
            ST_DATA: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        owner_d = OWN_NONE;
        if (grant_cpu) begin
            owner_d = OWN_CPU;
        end else if (grant_vid) begin
            owner_d = OWN_VID;
        end

        // Counts video wins against a waiting CPU; any CPU win or idle CPU resets it.
        burst_d = burst_q;
        if (grant_cpu || !CPU_REQ) begin
            burst_d = '0;
        end else if (grant_vid && (burst_q != BURST_MAX)) begin
            burst_d = burst_q + 4'd1;
        end
    end

    always_comb begin
        MEM_A = '0;
        if (grant_cpu) begin
            MEM_A = CPU_A;
        end else if (grant_vid) begin
            MEM_A = VID_A;
        end
        MEM_W   = grant_cpu && CPU_W;
        MEM_DO  = CPU_DO;
        VID_ACK = grant_vid;

        VID_VALID = (owner_q == OWN_VID);
        VID_DI    = (owner_q == OWN_VID) ? MEM_DI : 8'h00;
        CPU_DI    = (owner_q == OWN_CPU) ? MEM_DI : 8'h00;

        // An IDLE CPU with no request runs freely; a waiting one is frozen.
        CPU_HOLD = 1'b0;
        if (RESET_N) begin
            CPU_HOLD = (state_q == ST_DATA) || !CPU_REQ;
        end

        DBG.state = state_q;
        DBG.owner = owner_q;
        DBG.burst = burst_q;
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a 64 KiB synchronous memory model.
module tb_mem_arb;
    import z80_mem_pkg::*;

    logic        CLOCK;
    logic        RESET_N;
    logic        CPU_REQ;
    logic [15:0] CPU_A;
    logic [7:0]  CPU_DO;
    logic        CPU_W;
    logic        CPU_HOLD;
    logic [7:0]  CPU_DI;
    logic        VID_REQ;
    logic [15:0] VID_A;
    logic        VID_ACK;
    logic        VID_VALID;
    logic [7:0]  VID_DI;
    logic [15:0] MEM_A;
    logic [7:0]  MEM_DO;
    logic        MEM_W;
    logic [7:0]  MEM_DI;
    arb_dbg_t    DBG;

    logic [7:0]  mem [0:65535];
    int          n_cmp;
    int          n_err;

    mem_arb #(.VID_BURST(4)) dut (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .CPU_REQ   (CPU_REQ),
        .CPU_A     (CPU_A),
        .CPU_DO    (CPU_DO),
        .CPU_W     (CPU_W),
        .CPU_HOLD  (CPU_HOLD),
        .CPU_DI    (CPU_DI),
        .VID_REQ   (VID_REQ),
        .VID_A     (VID_A),
        .VID_ACK   (VID_ACK),
        .VID_VALID (VID_VALID),
        .VID_DI    (VID_DI),
        .MEM_A     (MEM_A),
        .MEM_DO    (MEM_DO),
        .MEM_W     (MEM_W),
        .MEM_DI    (MEM_DI),
        .DBG       (DBG)
    );

    // Clock / reset
    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // Memory model: contents are addr[7:0]^addr[15:8] except 0x1234 = 0xA5.
    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i) ^ 8'(i >> 8);
        end
        mem[16'h1234] = 8'hA5;
        MEM_DI = 8'h00;
        forever begin
            @(posedge CLOCK);
            if (MEM_W) mem[MEM_A] <= MEM_DO;
            MEM_DI <= mem[MEM_A];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLOCK);
    endtask

    task automatic drive(input logic creq, input logic [15:0] ca, input logic cw,
                         input logic [7:0] cdo, input logic vreq, input logic [15:0] va);
        CPU_REQ = creq;
        CPU_A   = ca;
        CPU_W   = cw;
        CPU_DO  = cdo;
        VID_REQ = vreq;
        VID_A   = va;
    endtask

    initial begin
        string pat;
        logic  is_c;
        n_cmp = 0;
        n_err = 0;

        // Reset with requests active: everything must stay quiet.
        RESET_N = 1'b0;
        drive(1'b1, 16'h1234, 1'b1, 8'h77, 1'b1, 16'h4000);
        sample();
        check("rst_hold",   32'(CPU_HOLD),  32'h0);
        check("rst_ack",    32'(VID_ACK),   32'h0);
        check("rst_valid",  32'(VID_VALID), 32'h0);
        check("rst_memw",   32'(MEM_W),     32'h0);
        check("rst_mema",   32'(MEM_A),     32'h0);
        check("rst_cpudi",  32'(CPU_DI),    32'h0);
        check("rst_viddi",  32'(VID_DI),    32'h0);
        check("rst_state",  32'(DBG.state), 32'(ST_IDLE));
        check("rst_owner",  32'(DBG.owner), 32'(OWN_NONE));
        check("rst_burst",  32'(DBG.burst), 32'h0);
        next_cycle();
        RESET_N = 1'b1;

        // Idle CPU runs freely.
        drive(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000);
        sample();
        check("idle_hold", 32'(CPU_HOLD), 32'h1);
        check("idle_ack",  32'(VID_ACK),  32'h0);
        next_cycle();

        // CPU read of 0x1234.
        drive(1'b1, 16'h1234, 1'b0, 8'h00, 1'b0, 16'h0000);
        sample();
        check("rd_mema", 32'(MEM_A),    32'h1234);
        check("rd_memw", 32'(MEM_W),    32'h0);
        check("rd_hold", 32'(CPU_HOLD), 32'h0);
        next_cycle();
        sample();
        check("rd_hold1",  32'(CPU_HOLD),  32'h1);
        check("rd_cpudi",  32'(CPU_DI),    32'hA5);
        check("rd_state",  32'(DBG.state), 32'(ST_DATA));
        check("rd_vvalid", 32'(VID_VALID), 32'h0);
        next_cycle();

        // CPU write 0x3C to 0x8000, then read it back.
        drive(1'b1, 16'h8000, 1'b1, 8'h3C, 1'b0, 16'h0000);
        sample();
        check("wr_memw",  32'(MEM_W),  32'h1);
        check("wr_mema",  32'(MEM_A),  32'h8000);
        check("wr_memdo", 32'(MEM_DO), 32'h3C);
        next_cycle();
        sample();
        check("wr_memw_data", 32'(MEM_W),    32'h0);
        check("wr_hold1",     32'(CPU_HOLD), 32'h1);
        next_cycle();
        drive(1'b1, 16'h8000, 1'b0, 8'h00, 1'b0, 16'h0000);
        sample();
        check("rb_mema", 32'(MEM_A), 32'h8000);
        check("rb_memw", 32'(MEM_W), 32'h0);
        next_cycle();
        sample();
        check("rb_hold1", 32'(CPU_HOLD), 32'h1);
        check("rb_cpudi", 32'(CPU_DI),   32'h3C);
        next_cycle();

        // Video streaming 0x4000..0x4007, CPU idle; data is 0x40^n.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h4000 + 16'(i));
            sample();
            check("vs_ack",  32'(VID_ACK), 32'h1);
            check("vs_mema", 32'(MEM_A),   32'h4000 + 32'(i));
            check("vs_hold", 32'(CPU_HOLD), 32'h1);
            if (i > 0) begin
                check("vs_valid", 32'(VID_VALID), 32'h1);
                check("vs_data",  32'(VID_DI),    32'h40 ^ 32'(i - 1));
            end else begin
                check("vs_valid0", 32'(VID_VALID), 32'h0);
            end
            next_cycle();
        end
        drive(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000);
        sample();
        check("vs_ack_end",   32'(VID_ACK),   32'h0);
        check("vs_valid_end", 32'(VID_VALID), 32'h1);
        check("vs_data_end",  32'(VID_DI),    32'h47);
        next_cycle();
        sample();
        check("vs_valid_off", 32'(VID_VALID), 32'h0);
        next_cycle();

        // Contention with both requests held: V,V,V,V,C,V,V,V,V,C.
        pat = "VVVVCVVVVC";
        drive(1'b1, 16'h1234, 1'b0, 8'h00, 1'b1, 16'h4010);
        for (int k = 0; k < 10; k++) begin
            is_c = (pat[k] == "C");
            sample();
            check("ct_ack",  32'(VID_ACK), is_c ? 32'h0 : 32'h1);
            check("ct_mema", 32'(MEM_A),   is_c ? 32'h1234 : 32'h4010);
            check("ct_hold", 32'(CPU_HOLD),
                  (k > 0 && pat[k-1] == "C") ? 32'h1 : 32'h0);
            check("ct_valid", 32'(VID_VALID),
                  (k > 0 && pat[k-1] == "V") ? 32'h1 : 32'h0);
            if (k == 4) check("ct_burst_sat", 32'(DBG.burst), 32'h4);
            next_cycle();
        end
        sample();
        check("ct_hold_end",  32'(CPU_HOLD), 32'h1);
        check("ct_cpudi_end", 32'(CPU_DI),   32'hA5);
        check("ct_ack_data",  32'(VID_ACK),  32'h1);
        next_cycle();

        // CPU drops its request: counter clears, then same-cycle start.
        drive(1'b0, 16'h1234, 1'b0, 8'h00, 1'b1, 16'h4020);
        sample();
        check("clr_ack",  32'(VID_ACK),  32'h1);
        check("clr_hold", 32'(CPU_HOLD), 32'h1);
        next_cycle();
        drive(1'b1, 16'h1234, 1'b0, 8'h00, 1'b1, 16'h4020);
        sample();
        check("clr_burst", 32'(DBG.burst), 32'h0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) sample();
            check("sc_ack",  32'(VID_ACK), (k == 4) ? 32'h0 : 32'h1);
            check("sc_hold", 32'(CPU_HOLD), 32'h0);
            next_cycle();
        end
        drive(1'b1, 16'h1234, 1'b0, 8'h00, 1'b0, 16'h0000);
        sample();
        check("sc_hold1", 32'(CPU_HOLD), 32'h1);
        check("sc_cpudi", 32'(CPU_DI),   32'hA5);
        next_cycle();

        // Reset in the cycle after a CPU read grant.
        drive(1'b1, 16'h1234, 1'b0, 8'h00, 1'b0, 16'h0000);
        sample();
        check("rm_mema", 32'(MEM_A), 32'h1234);
        next_cycle();
        RESET_N = 1'b0;
        sample();
        check("rm_hold",  32'(CPU_HOLD),  32'h0);
        check("rm_valid", 32'(VID_VALID), 32'h0);
        check("rm_cpudi", 32'(CPU_DI),    32'h0);
        next_cycle();
        drive(1'b1, 16'h1234, 1'b0, 8'h00, 1'b1, 16'h4030);
        RESET_N = 1'b1;
        sample();
        check("rm_post_hold",  32'(CPU_HOLD),  32'h0);
        check("rm_post_valid", 32'(VID_VALID), 32'h0);
        check("rm_post_ack",   32'(VID_ACK),   32'h1);
        check("rm_post_state", 32'(DBG.state), 32'(ST_IDLE));
        next_cycle();
        sample();
        check("rm_post_valid1", 32'(VID_VALID), 32'h1);
        check("rm_post_data",   32'(VID_DI),    32'h70);
        check("rm_post_hold1",  32'(CPU_HOLD),  32'h0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
